mdu_seq: RTL
============

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 CLK  in  1  clock, rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start  in  1  request; sampled only in IDLE or DONE.
REQ-005 Op  in  2  operation: 00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder).
REQ-006 Signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 Operand1  in  WIDTH  multiplicand / dividend.
REQ-008 Operand2  in  WIDTH  multiplier / divisor.
REQ-009 WA3  in  4  destination register tag.
REQ-010 Result  out  WIDTH  selected result, held until next accepted Start.
REQ-011 Busy  out  1  high while an operation is in progress.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 DivZero  out  1  DIV/REM divisor was zero; valid with Done, held with Result.
REQ-014 MCycleWA3  out  4  WA3 captured at Start acceptance.
REQ-015 MPushIn  out  1  Done delayed one cycle (register).

Function
REQ-016 States: IDLE, RUN, DONE; Busy = (state == RUN).
REQ-017 IDLE/DONE with Start=1 at edge E: capture operands (magnitudes if signed), Op, Signed, WA3; iteration counter = 0; state -> RUN.
REQ-018 RUN: one shift-add (MUL/MULH) or restoring shift-subtract (DIV/REM) step per cycle; WIDTH steps, then one sign-correction cycle.
REQ-019 Done asserted in the cycle after edge E+WIDTH+1; state DONE lasts exactly one cycle, then IDLE unless Start=1 (back-to-back accepted, no bubble).
REQ-020 Start while RUN ignored; captured operands, Op, and MCycleWA3 unchanged.
REQ-021 Multiply: full 2*WIDTH product; MUL returns bits [WIDTH-1:0], MULH bits [2*WIDTH-1:WIDTH]; signed product negated iff operand signs differ.
REQ-022 Divide: quotient negated iff signs differ; remainder takes dividend sign.
REQ-023 Divisor zero: skip RUN; state -> DONE at edge E (Done one cycle after acceptance); DIV result all ones, REM result = Operand1; DivZero=1.
REQ-024 Signed overflow (most-negative / -1): quotient = most-negative value, remainder 0, DivZero=0; full latency.
REQ-025 DivZero cleared on every accepted Start that does not hit REQ-023.
REQ-026 MPushIn = Done registered one cycle.

Reset
REQ-027 Reset asserted: state IDLE; Result, MCycleWA3, DivZero, Busy, Done, MPushIn, and all internal registers to 0 immediately.
REQ-028 Reset mid-operation aborts; no Done/MPushIn pulse for the aborted operation.

Configuration
REQ-029 Macro MDU_SIGNED_EN defined: Signed input honoured per REQ-021..024.
REQ-030 MDU_SIGNED_EN undefined: Signed ignored, all ops unsigned, sign-correction cycle retained as idle so latency is unchanged, overflow logic removed.

Verification (WIDTH=32, MDU_SIGNED_EN defined)
REQ-031 MUL 7*6, Signed=0, WA3=5 -> Done 33 cycles after Start edge, Result=42, MCycleWA3=5, MPushIn one cycle later.
REQ-032 MULH 0xFFFFFFFD*2: Signed=1 -> Result 0xFFFFFFFF; Signed=0 -> Result 0x00000001.
REQ-033 DIV -7/2 Signed=1 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF signed -> 0x80000000, DivZero=0.
REQ-034 DIV 5/0 -> Done 1 cycle after acceptance, Result 0xFFFFFFFF, DivZero=1; REM 5/0 -> Result 5.
REQ-035 Start MUL 3*4, re-Start at cycle 10 with other operands -> ignored, Result 12; Start during DONE -> second op accepted, Busy next cycle.
REQ-036 Reset at cycle 10 of a DIV -> Busy=0, outputs 0, no Done pulse within 40 cycles.

Source files
------------

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Define MDU_SIGNED_EN to honour the Signed input; without it every operation is unsigned.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   input  logic [3:0]       WA3,
   output logic [WIDTH-1:0] Result,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [3:0]       MCycleWA3,
   output logic             MPushIn
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MDU_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [1:0]         op;
   logic               neg_main;
   logic               neg_rem;
   logic               ovf;

   logic               accept;
   logic               div_zero;
   logic               sign_mode;
   logic               neg1;
   logic               neg2;
   logic               ovf_req;
   logic               last_step;
   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   result_next;

   assign accept    = Start && (state != RUN);
   assign div_zero  = Op[1] && (Operand2 == '0);
   assign sign_mode = SIGNED_EN && Signed;
   assign neg1      = sign_mode && Operand1[WIDTH-1];
   assign neg2      = sign_mode && Operand2[WIDTH-1];
   assign mag1      = neg1 ? -Operand1 : Operand1;
   assign mag2      = neg2 ? -Operand2 : Operand2;
   assign last_step = (count == CW'(WIDTH));

`ifdef MDU_SIGNED_EN
   assign ovf_req = sign_mode && Op[1] && (Operand1 == MOST_NEG) && (Operand2 == '1);
`else
   assign ovf_req = 1'b0;
`endif

   // The accumulator holds {high, low} of the product or {remainder, quotient} of the division.
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_ok    = ~div_diff[WIDTH];
   assign step_acc  = op[1] ? {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok}
                            : {mul_sum, acc[WIDTH-1:1]};

   assign prod_fix = neg_main ? -acc : acc;
   assign quot_fix = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      result_next = '0;
      case (op)
         2'b00:   result_next = prod_fix[WIDTH-1:0];
         2'b01:   result_next = prod_fix[2*WIDTH-1:WIDTH];
         2'b10:   result_next = ovf ? MOST_NEG : quot_fix;
         default: result_next = ovf ? '0 : rem_fix;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // A zero divisor bypasses the iteration and completes straight away.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (Start) state_next = div_zero ? DONE : RUN;
            else       state_next = IDLE;
         end
         RUN:     if (last_step) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state)
         RUN:     Busy = 1'b1;
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         count     <= '0;
         acc       <= '0;
         opb       <= '0;
         op        <= '0;
         neg_main  <= 1'b0;
         neg_rem   <= 1'b0;
         ovf       <= 1'b0;
         Result    <= '0;
         DivZero   <= 1'b0;
         MCycleWA3 <= '0;
      end else if (accept) begin
         count     <= '0;
         acc       <= {{WIDTH{1'b0}}, mag1};
         opb       <= mag2;
         op        <= Op;
         neg_main  <= neg1 ^ neg2;
         neg_rem   <= neg1;
         ovf       <= ovf_req;
         DivZero   <= div_zero;
         MCycleWA3 <= WA3;
         if (div_zero) Result <= Op[0] ? Operand1 : '1;
      end else if (state == RUN) begin
         if (last_step) begin
            Result <= result_next;
         end else begin
            acc   <= step_acc;
            count <= count + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) MPushIn <= 1'b0;
      else       MPushIn <= Done;
   end

endmodule
